adder_datapath_seq: RTL

Parametrised multi-cycle accumulator datapath, the successor to the fixed 16-bit carry-ripple adder datapath. It computes A <= A + B or A <= A - B one SLICE-bit slice per clock, using a registered carry between slices. B is loaded from switches (Din), and the result is exposed as {carry-out, A}. It sits between the board switch/key debouncers and the hex/LED drivers, with widths set by parameters.

---
 rtl/adder_datapath_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/adder_datapath_seq.sv
// Multi-cycle accumulator datapath: A <= A +/- B, one SLICE-bit slice per clock with a
// registered inter-slice carry. Result is exposed as {cout, A}.
module adder_datapath_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             LoadB,
  input  logic             ClearA,
  input  logic             Sub,
  input  logic             Run,
  output logic [WIDTH:0]   reg_out,
  output logic             Busy,
  output logic             Done,
  output logic             Ovf,
  output logic [3:0]       LED
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("adder_datapath_seq: SLICE must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cout_q;
  logic             carry_q;
  logic             ovf_q;
  logic             sub_q;
  logic             run_prev_q;
  logic [IdxW-1:0]  idx_q;

  logic             start;
  logic [31:0]      base;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE:0]   sum;
  logic             ovf_next;

  // Slice adder; on the last slice the slice MSBs are the word MSBs, giving signed overflow.
  always_comb begin
    start    = (state_q == StIdle) && run_prev_q && !Run;
    base     = 32'(idx_q) * SLICE;
    a_s      = a_q[base +: SLICE];
    b_s      = b_q[base +: SLICE] ^ {SLICE{sub_q}};
    sum      = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
    ovf_next = (a_s[SLICE-1] == b_s[SLICE-1]) && (sum[SLICE-1] != a_s[SLICE-1]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      cout_q     <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      sub_q      <= 1'b0;
      run_prev_q <= 1'b1;
      idx_q      <= '0;
    end else begin
      run_prev_q <= Run;
      unique case (state_q)
        StIdle: begin
          if (!LoadB) b_q <= Din;
          if (start) begin
            sub_q   <= Sub;
            carry_q <= Sub;
            idx_q   <= '0;
            state_q <= StAdd;
          end else if (!ClearA) begin
            a_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        StAdd: begin
          a_q[base +: SLICE] <= sum[SLICE-1:0];
          carry_q            <= sum[SLICE];
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            cout_q  <= sum[SLICE];
            ovf_q   <= ovf_next;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // Only leave once Run is seen high, so a held-low Run cannot retrigger.
          if (Run) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    reg_out = {cout_q, a_q};
    Busy    = (state_q == StAdd);
    Done    = (state_q == StDone);
    Ovf     = ovf_q;
    LED     = {Done, Busy, sub_q, Ovf};
  end

endmodule
